// File: rtl/egyptian_divider.sv
// egyptian_divider: restoring shift-subtract divider, one quotient bit per clock.
// Ports: clk, rst, in_valid/in_ready/dividend/divisor in, out_valid/out_ready/quotient/remainder/div_by_zero out.
module egyptian_divider #(
  parameter int WIDTH_N = 32,
  parameter int WIDTH_D = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH_N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH_N-1:0] n;
  logic [WIDTH_N-1:0] q;
  logic [WIDTH_D-1:0] d;
  logic [WIDTH_D-1:0] dlo;
  logic [WIDTH_D-1:0] r;
  logic [WIDTH_D:0]   rs;
  logic [WIDTH_D-1:0] diff;
  logic               ge;
  logic [CW-1:0]      cnt;
  logic               zf;

  // r < d after every step, so the stored remainder fits in WIDTH_D bits;
  // only the shifted value needs the extra bit for the compare.
  always_comb begin
    rs   = {r, n[WIDTH_N-1]};
    ge   = (rs >= {1'b0, d});
    diff = rs[WIDTH_D-1:0] - d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      n           <= '0;
      q           <= '0;
      d           <= '0;
      dlo         <= '0;
      r           <= '0;
      cnt         <= '0;
      zf          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            n        <= dividend;
            d        <= divisor;
            dlo      <= dividend[WIDTH_D-1:0];
            r        <= '0;
            q        <= '0;
            cnt      <= '0;
            zf       <= (divisor == '0);
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (cnt == CW'(WIDTH_N)) begin
            // Zero divisor still runs full length; only the result is replaced.
            quotient    <= zf ? '1 : q;
            remainder   <= zf ? dlo : r;
            div_by_zero <= zf;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            n   <= n << 1;
            r   <= ge ? diff : rs[WIDTH_D-1:0];
            q   <= {q[WIDTH_N-2:0], ge};
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
